// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache (read-only) and the D-cache (read/write).
// Tie-breaking alternates on the last grantee, and a RELEASE cycle follows every completion.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  i_cnt,
  output logic [CNT_W-1:0]  d_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_last;
  logic [CNT_W-1:0]   r_i_cnt;
  logic [CNT_W-1:0]   r_d_cnt;
  logic               w_i_req;
  logic               w_d_req;
  logic               w_i_done;
  logic               w_d_done;

  assign w_i_req  = i_read;
  assign w_d_req  = d_read | d_write;
  assign w_i_done = (r_state == GRANT_I) && mem_ready;
  assign w_d_done = (r_state == GRANT_D) && mem_ready;

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_cnt   = r_i_cnt;
  assign d_cnt   = r_d_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b0;
      r_i_cnt <= '0;
      r_d_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_i_done) begin
        r_last <= 1'b0;
        if (r_i_cnt != '1) r_i_cnt <= r_i_cnt + CNT_W'(1);
      end
      if (w_d_done) begin
        r_last <= 1'b1;
        if (r_d_cnt != '1) r_d_cnt <= r_d_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    busy         = 1'b1;
    owner        = r_last;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        // On a tie the port that was not served last wins.
        if (w_i_req && w_d_req) w_next_state = r_last ? GRANT_I : GRANT_D;
        else if (w_i_req)       w_next_state = GRANT_I;
        else if (w_d_req)       w_next_state = GRANT_D;
      end
      GRANT_I: begin
        owner    = 1'b0;
        mem_read = i_read;
        mem_addr = i_addr;
        i_ready  = mem_ready;
        if (mem_ready) w_next_state = RELEASE;
      end
      GRANT_D: begin
        owner     = 1'b1;
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
        if (mem_ready) w_next_state = RELEASE;
      end
      RELEASE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; a second instance with 2-bit counters exercises saturation.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              busy;
  logic              owner;
  logic [CNT_W-1:0]  i_cnt;
  logic [CNT_W-1:0]  d_cnt;

  logic [LINE_W-1:0] s_i_rdata, s_d_rdata, s_mem_wdata;
  logic              s_i_ready, s_d_ready, s_mem_read, s_mem_write, s_busy, s_owner;
  logic [ADDR_W-1:0] s_mem_addr;
  logic [1:0]        s_i_cnt, s_d_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner), .i_cnt(i_cnt), .d_cnt(d_cnt)
  );

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(s_i_rdata), .i_ready(s_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_ready(s_d_ready),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(s_busy), .owner(s_owner), .i_cnt(s_i_cnt), .d_cnt(s_d_cnt)
  );

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [LINE_W-1:0] line_a5;
    logic [LINE_W-1:0] wline;
    line_a5 = {16{8'hA5}};
    wline   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Reset state
    #2;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_i_cnt", i_cnt, 0);
    cyc();
    rst = 1'b1;

    // Single I-cache read, memory latency 5
    i_read = 1'b1; i_addr = 28'h10;
    #1;
    check("i1_idle_mem_read", mem_read, 0);
    cyc();
    #1;
    check("i1_grant_mem_read", mem_read, 1);
    check("i1_grant_addr", mem_addr, 28'h10);
    check("i1_grant_busy", busy, 1);
    check("i1_grant_owner", owner, 0);
    check("i1_no_ready_early", i_ready, 0);
    for (int k = 0; k < 4; k++) cyc();
    mem_ready = 1'b1; mem_rdata = line_a5;
    #1;
    check("i1_mem_read_held", mem_read, 1);
    check("i1_ready", i_ready, 1);
    check("i1_rdata", i_rdata, line_a5);
    check("i1_d_ready_zero", d_ready, 0);
    cyc();
    mem_ready = 1'b0; i_read = 1'b0;
    #1;
    check("i1_release_busy", busy, 1);
    check("i1_release_mem_read", mem_read, 0);
    check("i1_i_cnt", i_cnt, 1);
    check("i1_d_cnt", d_cnt, 0);
    cyc();
    check("i1_back_idle", busy, 0);

    // Tie right after reset: D-cache first, then I-cache
    rst = 1'b0; #1; rst = 1'b1;
    i_read = 1'b1; i_addr = 28'h20;
    d_read = 1'b1; d_addr = 28'h30;
    cyc();
    check("tie_first_owner", owner, 1);
    check("tie_first_addr", mem_addr, 28'h30);
    check("tie_first_mem_read", mem_read, 1);
    mem_ready = 1'b1;
    #1;
    check("tie_d_ready", d_ready, 1);
    check("tie_i_ready_zero", i_ready, 0);
    cyc();
    mem_ready = 1'b0; d_read = 1'b0;
    check("tie_release_owner", owner, 1);
    check("tie_d_cnt", d_cnt, 1);
    cyc();
    check("tie_idle_busy", busy, 0);
    cyc();
    check("tie_second_owner", owner, 0);
    check("tie_second_addr", mem_addr, 28'h20);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    check("tie_i_cnt", i_cnt, 1);
    cyc();

    // Both held: grants alternate D, I, D, I
    d_write = 1'b1; d_wdata = wline;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("alt_owner", owner, (k % 2 == 0) ? 1 : 0);
      mem_ready = 1'b1;
      #1;
      check("alt_ready", {i_ready, d_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      mem_ready = 1'b0;
      cyc();
    end
    check("alt_i_cnt", i_cnt, 3);
    check("alt_d_cnt", d_cnt, 3);
    i_read = 1'b0; d_write = 1'b0;
    cyc();

    // d_read and d_write together: write wins
    d_read = 1'b1; d_write = 1'b1; d_addr = 28'h44;
    cyc();
    check("rw_mem_write", mem_write, 1);
    check("rw_mem_read", mem_read, 0);
    check("rw_mem_wdata", mem_wdata, wline);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0; d_read = 1'b0; d_write = 1'b0;
    check("rw_d_cnt", d_cnt, 4);
    cyc();

    // Spurious mem_ready in IDLE
    mem_ready = 1'b1;
    #1;
    check("spur_i_ready", i_ready, 0);
    check("spur_d_ready", d_ready, 0);
    cyc();
    mem_ready = 1'b0;
    check("spur_i_cnt", i_cnt, 3);
    check("spur_d_cnt", d_cnt, 4);
    check("spur_idle", busy, 0);

    // Reset during GRANT_D
    d_write = 1'b1; d_addr = 28'h55;
    cyc();
    check("rstmid_mem_write", mem_write, 1);
    rst = 1'b0;
    #1;
    check("rstmid_write_drop", mem_write, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_i_cnt", i_cnt, 0);
    check("rstmid_d_cnt", d_cnt, 0);
    d_write = 1'b0;
    cyc();
    rst = 1'b1;

    // Four I reads: 2-bit counter saturates at 3, 16-bit counter reaches 4
    i_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      mem_ready = 1'b1;
      cyc();
      mem_ready = 1'b0;
      check("sat_small_cnt", s_i_cnt, (k < 3) ? k + 1 : 3);
      cyc();
    end
    i_read = 1'b0;
    check("sat_big_cnt", i_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
